priority_arbiter_n: RTL and testbench

- Registered N-way request arbiter; parametrised successor to the team's 8:3 combinational priority encoder.
- Adds a selectable round-robin mode, a held grant with valid/ack handshake, grant withdrawal, and back-to-back arbitration.
- Sits between N requesters and one shared resource, such as a bus port or a single-issue unit.
- In fixed mode the winner matches the encoder: highest set index wins.

---
 rtl/priority_arbiter_n_if.sv | 27 ++
 rtl/priority_arbiter_n.sv | 119 +++++++++++
 tb/tb_priority_arbiter_n.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/priority_arbiter_n_if.sv
// Request/grant bundle between N requesters and the arbiter.
// Handshake: a grant is offered while gnt_valid=1 and stays stable until the
// edge where gnt_ack=1 (completion) or the granted requester drops its req bit
// (withdrawal); gnt_ack is ignored while gnt_valid=0.
interface priority_arbiter_n_if #(
  parameter int N     = 8,
  parameter int IDX_W = $clog2(N)
);
  logic             mode;
  logic [N-1:0]     req;
  logic             gnt_ack;
  logic             gnt_valid;
  logic [IDX_W-1:0] gnt_idx;
  logic [N-1:0]     gnt_onehot;
  logic             idle;
  logic             dbg_state;

  modport master (
    output mode, req, gnt_ack,
    input  gnt_valid, gnt_idx, gnt_onehot, idle, dbg_state
  );

  modport slave (
    input  mode, req, gnt_ack,
    output gnt_valid, gnt_idx, gnt_onehot, idle, dbg_state
  );
endinterface

// File: rtl/priority_arbiter_n.sv
// Registered N-way arbiter: fixed (highest index wins) or round-robin priority,
// with a held grant, ack-driven completion, withdrawal and back-to-back
// re-arbitration. All outputs come straight from flops.
module priority_arbiter_n #(
  parameter int N     = 8,
  parameter int IDX_W = $clog2(N)
) (
  input logic                clk,
  input logic                rst_n,
  priority_arbiter_n_if.slave bus
);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  state_t           r_state;
  logic             r_gnt_valid;
  logic [IDX_W-1:0] r_gnt_idx;
  logic [N-1:0]     r_gnt_onehot;
  logic             r_idle;
  logic [IDX_W-1:0] r_ptr;

  logic             w_ack_done;
  logic             w_held_req;
  logic [IDX_W-1:0] w_ptr_nxt;
  logic [IDX_W-1:0] w_search_ptr;
  logic             w_found;
  logic [IDX_W-1:0] w_win_idx;
  logic [N-1:0]     w_win_onehot;

  assign w_ack_done   = (r_state == S_GRANT) && bus.gnt_ack;
  assign w_held_req   = bus.req[r_gnt_idx];
  assign w_win_onehot = N'(1) << w_win_idx;

  // Pointer after this edge: on a round-robin completion the finished index
  // becomes lowest priority. Fixed mode is the same search started at N-1.
  always_comb begin
    w_ptr_nxt = r_ptr;
    if (w_ack_done && bus.mode) begin
      w_ptr_nxt = (r_gnt_idx == '0) ? IDX_W'(N - 1) : r_gnt_idx - IDX_W'(1);
    end
    w_search_ptr = bus.mode ? w_ptr_nxt : IDX_W'(N - 1);
  end

  // Descending wrapped search from w_search_ptr; the lowest step count wins,
  // so later loop iterations (closer to the pointer) overwrite earlier ones.
  always_comb begin
    logic [IDX_W-1:0] v_cand;
    w_found   = 1'b0;
    w_win_idx = '0;
    v_cand    = '0;
    for (int j = N - 1; j >= 0; j--) begin
      v_cand = IDX_W'((int'(w_search_ptr) + N - j) % N);
      if (bus.req[v_cand]) begin
        w_found   = 1'b1;
        w_win_idx = v_cand;
      end
    end
  end

  // Grant FSM with registered outputs and round-robin pointer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_gnt_valid  <= 1'b0;
      r_gnt_idx    <= '0;
      r_gnt_onehot <= '0;
      r_idle       <= 1'b1;
      r_ptr        <= IDX_W'(N - 1);
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_state      <= S_GRANT;
            r_gnt_valid  <= 1'b1;
            r_gnt_idx    <= w_win_idx;
            r_gnt_onehot <= w_win_onehot;
            r_idle       <= 1'b0;
          end else begin
            r_idle <= ~|bus.req;
          end
        end
        S_GRANT: begin
          if (bus.gnt_ack) begin
            // Completion (wins over a simultaneous withdrawal).
            r_ptr <= w_ptr_nxt;
            if (w_found) begin
              r_gnt_idx    <= w_win_idx;
              r_gnt_onehot <= w_win_onehot;
            end else begin
              r_state      <= S_IDLE;
              r_gnt_valid  <= 1'b0;
              r_gnt_idx    <= '0;
              r_gnt_onehot <= '0;
              r_idle       <= 1'b1;
            end
          end else if (!w_held_req) begin
            // Withdrawal: release now, re-arbitrate next edge.
            r_state      <= S_IDLE;
            r_gnt_valid  <= 1'b0;
            r_gnt_idx    <= '0;
            r_gnt_onehot <= '0;
            r_idle       <= ~|bus.req;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.gnt_valid  = r_gnt_valid;
  assign bus.gnt_idx    = r_gnt_idx;
  assign bus.gnt_onehot = r_gnt_onehot;
  assign bus.idle       = r_idle;
  assign bus.dbg_state  = r_state;

endmodule

// File: tb/tb_priority_arbiter_n.sv
// Bench for priority_arbiter_n: behavioural model checked every cycle,
// directed vectors with literal expectations and a grant-order queue.
module tb_priority_arbiter_n;
  localparam int N = 8;

  // Clock and reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  priority_arbiter_n_if #(.N(N)) bus ();
  priority_arbiter_n #(.N(N)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  priority_arbiter_n_if #(.N(2)) bus2 ();
  priority_arbiter_n #(.N(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

  int n_tests = 0;
  int n_fail  = 0;
  logic [2:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference arbitration rule.
  function automatic int win(input logic [N-1:0] r, input logic m, input int p);
    if (r == '0) return -1;
    if (!m) begin
      for (int i = N - 1; i >= 0; i--) if (r[i]) return i;
    end else begin
      for (int j = 0; j < N; j++) begin
        int i;
        i = (p - j + N) % N;
        if (r[i]) return i;
      end
    end
    return -1;
  endfunction

  // Model state
  logic       m_on = 1'b0;
  logic       m_valid;
  int         m_idx;
  int         m_ptr;
  logic       m_idle;
  logic [N-1:0] m_oh;

  // Model update at each edge, then compare against the DUT just after.
  always @(posedge clk) begin
    logic [N-1:0] r;
    logic m, a;
    logic [2:0] e;
    r = bus.req;
    m = bus.mode;
    a = bus.gnt_ack;
    if (rst_n && bus.gnt_valid === 1'b1 && a && exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("grant_order", 64'(bus.gnt_idx), 64'(e));
    end
    if (!rst_n) begin
      m_on = 1'b1; m_valid = 1'b0; m_idx = 0; m_ptr = N - 1; m_idle = 1'b1;
    end else if (!m_valid) begin
      if (r != '0) begin
        m_valid = 1'b1; m_idx = win(r, m, m_ptr); m_idle = 1'b0;
      end else begin
        m_idle = 1'b1;
      end
    end else if (a) begin
      if (m) m_ptr = (m_idx == 0) ? N - 1 : m_idx - 1;
      if (r != '0) begin
        m_idx = win(r, m, m_ptr);
      end else begin
        m_valid = 1'b0; m_idx = 0; m_idle = 1'b1;
      end
    end else if (!r[m_idx]) begin
      m_valid = 1'b0; m_idx = 0; m_idle = (r == '0);
    end
    m_oh = m_valid ? (N'(1) << m_idx) : '0;
    #1;
    if (m_on) begin
      check("model_valid", 64'(bus.gnt_valid), 64'(m_valid));
      check("model_idx", 64'(bus.gnt_idx), 64'(m_idx));
      check("model_onehot", 64'(bus.gnt_onehot), 64'(m_oh));
      check("model_idle", 64'(bus.idle), 64'(m_idle));
    end
  end

  // Driver: apply inputs, then advance to the next falling edge.
  task automatic cyc(input logic m, input logic [N-1:0] r, input logic a);
    bus.mode = m;
    bus.req = r;
    bus.gnt_ack = a;
    @(negedge clk);
  endtask

  initial begin
    bus.mode = 1'b0; bus.req = '0; bus.gnt_ack = 1'b0;
    bus2.mode = 1'b0; bus2.req = '0; bus2.gnt_ack = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_valid", 64'(bus.gnt_valid), 64'd0);
    check("rst_onehot", 64'(bus.gnt_onehot), 64'd0);
    check("rst_idle", 64'(bus.idle), 64'd1);
    rst_n = 1'b1;

    // Fixed mode, 0010_0110 held, ack every grant
    repeat (5) exp_q.push_back(3'd5);
    cyc(0, 8'b0010_0110, 1);
    check("fix_idx", 64'(bus.gnt_idx), 64'd5);
    check("fix_onehot", 64'(bus.gnt_onehot), 64'h20);
    repeat (4) cyc(0, 8'b0010_0110, 1);
    cyc(0, 8'h00, 1);
    cyc(0, 8'h00, 0);
    check("fix_idle", 64'(bus.idle), 64'd1);
    check("fix_valid0", 64'(bus.gnt_valid), 64'd0);

    // Round-robin, 1000_0011 back-to-back
    foreach (exp_q[i]) ;
    exp_q.push_back(3'd7); exp_q.push_back(3'd1); exp_q.push_back(3'd0);
    exp_q.push_back(3'd7); exp_q.push_back(3'd1); exp_q.push_back(3'd0);
    for (int k = 0; k < 6; k++) begin
      cyc(1, 8'b1000_0011, 1);
      check("rr_b2b_valid", 64'(bus.gnt_valid), 64'd1);
    end
    cyc(1, 8'h00, 1);

    // Round-robin, all requesting, 16 acks with pointer wrap
    for (int k = 0; k < 16; k++) exp_q.push_back(3'(7 - (k % 8)));
    repeat (16) cyc(1, 8'hFF, 1);
    cyc(1, 8'h00, 1);
    check("rr_queue_drained", 64'(exp_q.size()), 64'd0);

    // Hold without pre-emption, then withdrawal
    cyc(0, 8'h08, 0);
    check("hold_grant3", 64'(bus.gnt_idx), 64'd3);
    cyc(0, 8'h88, 0);
    check("hold_no_preempt", 64'(bus.gnt_idx), 64'd3);
    cyc(0, 8'h80, 0);
    check("withdraw_valid", 64'(bus.gnt_valid), 64'd0);
    check("withdraw_idle", 64'(bus.idle), 64'd0);
    cyc(0, 8'h80, 0);
    check("withdraw_regrant", 64'(bus.gnt_idx), 64'd7);
    cyc(0, 8'h00, 1);

    // Move ptr to 1, grant 4, then reset mid-grant
    cyc(1, 8'h04, 0);
    check("rr_grant2", 64'(bus.gnt_idx), 64'd2);
    cyc(1, 8'h00, 1);
    cyc(1, 8'h10, 0);
    check("rr_grant4", 64'(bus.gnt_idx), 64'd4);
    rst_n = 1'b0;
    cyc(1, 8'h10, 0);
    rst_n = 1'b1;
    check("midrst_valid", 64'(bus.gnt_valid), 64'd0);
    check("midrst_onehot", 64'(bus.gnt_onehot), 64'd0);
    check("midrst_idle", 64'(bus.idle), 64'd1);
    cyc(1, 8'h11, 0);
    check("midrst_ptr", 64'(bus.gnt_idx), 64'd4);

    // Ack and withdrawal on the same edge: ack wins, back-to-back to 0
    cyc(1, 8'h01, 1);
    check("ackwins_valid", 64'(bus.gnt_valid), 64'd1);
    check("ackwins_idx", 64'(bus.gnt_idx), 64'd0);
    cyc(1, 8'h00, 1);

    // Mode change during a held grant
    cyc(0, 8'h81, 0);
    check("mode_grant7", 64'(bus.gnt_idx), 64'd7);
    cyc(1, 8'h81, 0);
    check("mode_hold7", 64'(bus.gnt_idx), 64'd7);
    cyc(1, 8'h00, 1);
    cyc(1, 8'hC0, 0);
    check("mode_rr6", 64'(bus.gnt_idx), 64'd6);
    cyc(1, 8'h00, 1);
    cyc(0, 8'h00, 0);

    // N=2 build, round-robin alternation
    check("n2_idle", 64'(bus2.idle), 64'd1);
    bus2.mode = 1'b1; bus2.req = 2'b11; bus2.gnt_ack = 1'b1;
    @(negedge clk);
    check("n2_g0", 64'(bus2.gnt_idx), 64'd1);
    @(negedge clk);
    check("n2_g1", 64'(bus2.gnt_idx), 64'd0);
    @(negedge clk);
    check("n2_g2", 64'(bus2.gnt_idx), 64'd1);
    @(negedge clk);
    check("n2_g3", 64'(bus2.gnt_idx), 64'd0);
    check("n2_valid", 64'(bus2.gnt_valid), 64'd1);
    bus2.req = 2'b00;
    @(negedge clk);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
